// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus a WIDTH-step
// unsigned shift-add multiplier producing a double-width product.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;

    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_next;

    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
        add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
        sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: begin
                alu_res  = sum_ext[WIDTH-1:0];
                alu_cout = sum_ext[WIDTH];
                alu_ovf  = add_ovf;
            end
            OP_SUB: begin
                alu_res  = diff_ext[WIDTH-1:0];
                alu_cout = diff_ext[WIDTH];
                alu_ovf  = sub_ovf;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH-1] ^ sub_ovf};
            OP_NOR: alu_res = ~(a | b);
            default: alu_res = '0;
        endcase
    end

    // Upper half accumulates the multiplicand when the current multiplier
    // LSB (prod[0]) is set, then the whole register shifts right one bit.
    always_comb begin
        step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {step_sum, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mcand     <= '0;
            prod      <= '0;
            count     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            state <= MUL;
                            busy  <= 1'b1;
                            mcand <= a;
                            prod  <= {{WIDTH{1'b0}}, b};
                            count <= '0;
                        end else begin
                            result    <= alu_res;
                            result_hi <= '0;
                            zero      <= (alu_res == '0);
                            cout      <= alu_cout;
                            overflow  <= alu_ovf;
                            done      <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod  <= prod_next;
                    count <= count + 1'b1;
                    // The final step's product goes straight to the outputs.
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        result    <= prod_next[WIDTH-1:0];
                        result_hi <= prod_next[2*WIDTH-1:WIDTH];
                        zero      <= (prod_next[WIDTH-1:0] == '0);
                        cout      <= 1'b0;
                        overflow  <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): a reference model pushes expected
// results to a scoreboard queue, and a monitor pops and compares them on done.
module tb_seq_alu;

    localparam int W    = 8;
    localparam int MAXS = 2 ** (W - 1) - 1;
    localparam int MINS = -(2 ** (W - 1));

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         cout;
    logic         overflow;
    logic         busy;
    logic         done;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] res_hi;
        logic         zero;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model written with plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] m_op, input logic [W-1:0] ma,
                                   input logic [W-1:0] mb);
        exp_t           e;
        int             sa;
        int             sb;
        int             s;
        logic [W:0]     w_sum;
        logic [2*W-1:0] p;
        e  = '0;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        case (m_op)
            OP_AND: e.res = ma & mb;
            OP_OR:  e.res = ma | mb;
            OP_ADD: begin
                w_sum  = {1'b0, ma} + {1'b0, mb};
                e.res  = w_sum[W-1:0];
                e.cout = w_sum[W];
                s      = sa + sb;
                e.ovf  = (s > MAXS) || (s < MINS);
            end
            OP_SUB: begin
                e.res  = ma - mb;
                e.cout = (ma >= mb);
                s      = sa - sb;
                e.ovf  = (s > MAXS) || (s < MINS);
            end
            OP_SLT: e.res = (sa < sb) ? W'(1) : '0;
            OP_NOR: e.res = ~(ma | mb);
            OP_MUL: begin
                p        = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
                e.res    = p[W-1:0];
                e.res_hi = p[2*W-1:W];
            end
            default: e.res = '0;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Drive one start pulse from a negedge; returns at the negedge after the
    // accepting edge.
    task automatic applyStimulus(input logic [2:0] s_op, input logic [W-1:0] sa,
                                 input logic [W-1:0] sb, input bit accepted);
        start = 1'b1;
        op    = s_op;
        a     = sa;
        b     = sb;
        if (accepted) sb_q.push_back(model(s_op, sa, sb));
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("sb_result", result, e.res);
                checkOutput("sb_result_hi", result_hi, e.res_hi);
                checkOutput("sb_zero", zero, e.zero);
                checkOutput("sb_cout", cout, e.cout);
                checkOutput("sb_overflow", overflow, e.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;

        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_result_hi", result_hi, 0);
        checkOutput("rst_zero", zero, 0);
        checkOutput("rst_cout", cout, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(OP_ADD, 8'hFF, 8'h01, 1'b1);
        checkOutput("add_done", done, 1);
        checkOutput("add_busy", busy, 0);
        checkOutput("add_result", result, 8'h00);
        checkOutput("add_zero", zero, 1);
        checkOutput("add_cout", cout, 1);
        @(negedge clk);
        checkOutput("add_done_one_cycle", done, 0);

        applyStimulus(OP_SUB, 8'h80, 8'h01, 1'b1);
        checkOutput("sub_result", result, 8'h7F);
        checkOutput("sub_cout", cout, 1);
        checkOutput("sub_overflow", overflow, 1);
        applyStimulus(OP_SLT, 8'hFF, 8'h01, 1'b1);
        checkOutput("slt_result", result, 8'h01);
        checkOutput("slt_overflow", overflow, 0);

        // Inputs wiggling without start must not disturb held outputs.
        op = OP_ADD;
        a  = 8'h05;
        b  = 8'h05;
        repeat (3) @(negedge clk);
        checkOutput("hold_result", result, 8'h01);
        checkOutput("hold_done", done, 0);

        applyStimulus(OP_MUL, 8'h0D, 8'h0B, 1'b1);
        for (int k = 1; k <= W; k++) begin
            checkOutput("mul_busy", busy, 1);
            checkOutput("mul_no_done", done, 0);
            if (k == 3) begin
                start = 1'b1;
                op    = OP_ADD;
                a     = 8'h01;
                b     = 8'h01;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("mul_done", done, 1);
        checkOutput("mul_busy_end", busy, 0);
        checkOutput("mul_result", result, 8'h8F);
        checkOutput("mul_result_hi", result_hi, 8'h00);

        applyStimulus(OP_MUL, 8'hFF, 8'hFF, 1'b1);
        repeat (W) @(negedge clk);
        checkOutput("mulff_done", done, 1);
        checkOutput("mulff_result", result, 8'h01);
        checkOutput("mulff_result_hi", result_hi, 8'hFE);
        checkOutput("mulff_zero", zero, 0);
        applyStimulus(OP_ADD, 8'h00, 8'h00, 1'b1);
        checkOutput("b2b_done", done, 1);
        checkOutput("b2b_result_hi", result_hi, 8'h00);
        checkOutput("b2b_zero", zero, 1);

        // Reset sampled on the edge performing step 4 aborts the multiply.
        applyStimulus(OP_MUL, 8'h0D, 8'h0B, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_result_hi", result_hi, 0);
        checkOutput("abort_zero", zero, 0);
        applyStimulus(OP_ADD, 8'h03, 8'h04, 1'b1);
        checkOutput("post_abort_done", done, 1);
        checkOutput("post_abort_result", result, 8'h07);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("abort_no_done", done, 0);
        end

        reset = 1'b1;
        start = 1'b1;
        op    = OP_ADD;
        a     = 8'h01;
        b     = 8'h01;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("rst_start_done", done, 0);
        @(negedge clk);
        checkOutput("rst_start_discard", done, 0);
        checkOutput("rst_start_result", result, 0);

        applyStimulus(OP_RSV, 8'h55, 8'hAA, 1'b1);
        checkOutput("rsv_done", done, 1);
        checkOutput("rsv_zero", zero, 1);

        applyStimulus(OP_NOR, 8'h0F, 8'hF0, 1'b1);
        applyStimulus(OP_AND, 8'hC3, 8'h5A, 1'b1);
        applyStimulus(OP_OR, 8'h81, 8'h18, 1'b1);
        applyStimulus(OP_ADD, 8'h7F, 8'h01, 1'b1);
        applyStimulus(OP_SLT, 8'h01, 8'hFF, 1'b1);

        for (int n = 0; n < 30; n++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = W'($urandom);
            r_b  = W'($urandom);
            applyStimulus(r_op, r_a, r_b, 1'b1);
            if (r_op == OP_MUL) repeat (W) @(negedge clk);
        end

        @(negedge clk);
        checkOutput("queue_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits; legal values 2..32.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin an operation.
REQ-005 The block SHALL have port op  input  3  operation select, sampled with start.
REQ-006 The block SHALL have ports a and b  input  WIDTH  operands, sampled with start.
REQ-007 The block SHALL have port result  output  WIDTH  registered result (low word for MUL).
REQ-008 The block SHALL have port result_hi  output  WIDTH  registered high word of the MUL product; 0 for all other ops.
REQ-009 The block SHALL have ports zero, cout, overflow  output  1 each  registered flags.
REQ-010 The block SHALL have port busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse marking a new valid result.

Function
REQ-012 op encoding SHALL be: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 MUL, 111 reserved (result 0, all flags from that 0).
REQ-013 ADD SHALL compute a+b modulo 2^WIDTH; SUB SHALL compute a + ~b + 1 modulo 2^WIDTH.
REQ-014 For ADD/SUB, cout SHALL be the carry out of bit WIDTH-1 (SUB: cout=1 means no borrow); overflow SHALL be set on signed two's-complement overflow.
REQ-015 SLT SHALL return result = 1 when signed a < signed b, else 0, computed as sign(a-b) XOR overflow(a-b); cout=overflow=0.
REQ-016 AND, OR, NOR, SLT, MUL and reserved SHALL drive cout=0 and overflow=0.
REQ-017 zero SHALL be 1 iff result (low word) equals 0.
REQ-018 FSM states SHALL be IDLE and MUL; start SHALL be accepted only when busy=0 and reset=0.
REQ-019 A single-cycle op accepted at edge T SHALL update result, result_hi, flags and assert done for exactly the cycle following edge T; the FSM stays IDLE.
REQ-020 MUL accepted at edge T SHALL latch a and b, enter MUL, set busy=1 and clear an iteration counter.
REQ-021 In MUL the block SHALL perform one unsigned shift-add step per cycle, WIDTH steps total, producing the full 2*WIDTH-bit product.
REQ-022 busy SHALL be high for exactly WIDTH cycles after MUL acceptance; on the edge ending the last step the FSM SHALL return to IDLE, load {result_hi,result} with the product and pulse done for one cycle.
REQ-023 start while busy=1 SHALL be ignored without effect on state, operands or outputs.
REQ-024 start may be asserted in the same cycle done is high; it SHALL be accepted normally (back-to-back).
REQ-025 result, result_hi and flags SHALL hold their last values between completions; changes to a, b or op without an accepted start SHALL have no effect.
REQ-026 Counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.

Reset
REQ-027 With reset high at a rising edge, the next state SHALL be IDLE, and result, result_hi, zero, cout, overflow, busy, done SHALL be 0 (zero SHALL be 0 out of reset, not derived).
REQ-028 Reset SHALL take priority over start and SHALL abort an in-progress MUL with no done pulse.
REQ-029 A start asserted in the cycle reset is high SHALL be discarded.

Verification (WIDTH=8)
REQ-030 ADD a=FF b=01, start at edge T -> cycle after T: result=00, zero=1, cout=1, overflow=0, done=1 for one cycle, busy=0.
REQ-031 SUB a=80 b=01 -> result=7F, cout=1, overflow=1; then SLT a=FF b=01 -> result=01, cout=0, overflow=0.
REQ-032 MUL a=0D b=0B at edge T -> busy=1 cycles T+1..T+8, done=1 only in cycle T+9 window, result=8F, result_hi=00; start with op=ADD during busy ignored.
REQ-033 MUL a=FF b=FF -> result_hi=FE, result=01, zero=0; immediately followed by start ADD a=00 b=00 in the done cycle -> next cycle result=00, result_hi=00, zero=1, done=1.
REQ-034 Reset asserted for one edge during MUL step 4 -> next cycle busy=0, done=0, all outputs 0; no done pulse follows; new start accepted one cycle later.
REQ-035 Reserved op 111 with a=55 b=AA -> result=00, result_hi=00, zero=1, cout=0, overflow=0, done pulsed.
